program_memory: RTL and testbench

Parametrised instruction memory for the accumulator CPU: a loader writes a program through a valid/ready stream, then the core fetches one instruction per cycle by PC address with a registered, 1-cycle read. It replaces the behavioural instruction array driven from the bench. Locations past the loaded program length read as HALT, so a core that runs off the end stops cleanly.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/progmem_ram.sv | 26 ++
 rtl/program_memory.sv | 153 +++++++++++++++
 tb/tb_program_memory.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: instruction encodings and the
// program memory state type.
package cpu_pkg;

    // Loader/fetch states of the program memory.
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        READY   = 2'd2
    } progmem_state_t;

    // NOP is the all-zero word at any width.
    function automatic logic [63:0] nop_enc(int w);
        nop_enc = 64'h0;
    endfunction

    // HALT puts 4'hF in the top nibble and zeros below (8'hF0 at width 8).
    function automatic logic [63:0] halt_enc(int w);
        halt_enc = 64'hF << (w - 4);
    endfunction

endpackage

// File: rtl/progmem_ram.sv
// Program storage array: one synchronous write port and one registered read
// port. The array has no reset; the owner decides which words are meaningful.
module progmem_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32,
    parameter int AW     = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port and registered read port share the clock.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/program_memory.sv
// Instruction memory for the accumulator CPU. A loader streams the program in
// (valid/ready), then the core fetches one word per cycle with 1-cycle latency.
// Addresses past the loaded length read as HALT.
//
// Optional feature macro: PROGMEM_FAULT_EN
//   defined   : fetches at or beyond DEPTH return HALT and set the sticky fault.
//   undefined : the fetch address wraps modulo DEPTH (DEPTH must be a power of
//               two) and fault is tied low.
//
// Load handshake: a word transfers on a rising edge where load_valid and
// load_ready are both high; load_ready depends only on the registered state,
// and a reload in the same cycle drops the transfer.
module program_memory
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 8
) (
    input  logic                       CLK,
    input  logic                       CLB,
    input  logic                       load_valid,
    input  logic [DATA_W-1:0]          load_data,
    input  logic                       load_last,
    output logic                       load_ready,
    input  logic                       reload,
    input  logic [ADDR_W-1:0]          fetch_addr,
    output logic [DATA_W-1:0]          fetch_data,
    output logic                       fetch_valid,
    output logic [$clog2(DEPTH+1)-1:0] prog_len,
    output logic                       fault,
    output progmem_state_t             dbg_state
);

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LEN_W = $clog2(DEPTH + 1);
    localparam int CMP_W = (ADDR_W > LEN_W) ? ADDR_W : LEN_W;

    localparam logic [DATA_W-1:0] NOP_W  = DATA_W'(nop_enc(DATA_W));
    localparam logic [DATA_W-1:0] HALT_W = DATA_W'(halt_enc(DATA_W));

    progmem_state_t    state_q;
    logic [LEN_W-1:0]  prog_len_q;
    logic              use_mem_q;
    logic [DATA_W-1:0] alt_q;
    logic              fetch_valid_q;

    logic              xfer;
    logic              last_slot;
    logic [AW-1:0]     rd_addr;
    logic              addr_hit;
    logic              addr_oob;
    logic [DATA_W-1:0] ram_rdata;

    assign load_ready = (state_q != READY);
    assign xfer       = load_valid & load_ready & ~reload;
    assign last_slot  = (prog_len_q == LEN_W'(DEPTH - 1));
    assign rd_addr    = fetch_addr[AW-1:0];

`ifdef PROGMEM_FAULT_EN
    assign addr_oob = (CMP_W'(fetch_addr) >= CMP_W'(DEPTH));
    assign addr_hit = ~addr_oob & (CMP_W'(fetch_addr) < CMP_W'(prog_len_q));
`else
    // High PC bits are ignored: the address wraps modulo DEPTH.
    logic unused_fetch_bits;
    assign unused_fetch_bits = ^fetch_addr;
    assign addr_oob = 1'b0;
    assign addr_hit = (CMP_W'(rd_addr) < CMP_W'(prog_len_q));
`endif

    progmem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk   (CLK),
        .we    (xfer),
        .waddr (prog_len_q[AW-1:0]),
        .wdata (load_data),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

    // Load FSM, length counter and the registered fetch qualifiers.
    always_ff @(posedge CLK or posedge CLB) begin
        if (CLB) begin
            state_q       <= EMPTY;
            prog_len_q    <= '0;
            use_mem_q     <= 1'b0;
            alt_q         <= NOP_W;
            fetch_valid_q <= 1'b0;
        end else begin
            case (state_q)
                EMPTY, LOADING: begin
                    if (reload) begin
                        state_q    <= EMPTY;
                        prog_len_q <= '0;
                    end else if (xfer) begin
                        prog_len_q <= prog_len_q + 1'b1;
                        state_q    <= (load_last || last_slot) ? READY : LOADING;
                    end
                end
                READY: begin
                    if (reload) begin
                        state_q    <= EMPTY;
                        prog_len_q <= '0;
                    end
                end
                default: begin
                    state_q    <= EMPTY;
                    prog_len_q <= '0;
                end
            endcase

            // Reload beats a concurrent fetch: the next result is NOP/invalid.
            if (state_q == READY && !reload) begin
                fetch_valid_q <= 1'b1;
                use_mem_q     <= addr_hit;
                alt_q         <= HALT_W;
            end else begin
                fetch_valid_q <= 1'b0;
                use_mem_q     <= 1'b0;
                alt_q         <= NOP_W;
            end
        end
    end

`ifdef PROGMEM_FAULT_EN
    logic fault_q;

    // Sticky out-of-range flag, cleared only by reset or reload.
    always_ff @(posedge CLK or posedge CLB) begin
        if (CLB) begin
            fault_q <= 1'b0;
        end else if (reload) begin
            fault_q <= 1'b0;
        end else if (state_q == READY && addr_oob) begin
            fault_q <= 1'b1;
        end
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    // The RAM read is already registered; the selector was registered with it.
    assign fetch_data  = use_mem_q ? ram_rdata : alt_q;
    assign fetch_valid = fetch_valid_q;
    assign prog_len    = prog_len_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_program_memory.sv
// Directed testbench for program_memory (DATA_W=8, DEPTH=32, ADDR_W=8).
module tb_program_memory;
    import cpu_pkg::*;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 8;
    localparam logic [7:0] HALT = 8'hF0;
    localparam logic [7:0] NOP  = 8'h00;

    logic              clk;
    logic              rst;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic              reload;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_valid;
    logic [5:0]        prog_len;
    logic              fault;
    progmem_state_t    dbg_state;

    int errors = 0;
    int checks = 0;

    logic [7:0] prog [19] = '{8'hD5, 8'h50, 8'h61, 8'h72, 8'h83,
                              8'h00, 8'h00, 8'h00,
                              8'hA4, 8'hB0, 8'hC1, 8'hD2, 8'hE3, 8'hA5, 8'hBF,
                              8'h11, 8'h22, 8'h33, 8'hF0};
    logic [DATA_W-1:0] exp_q[$];

    program_memory #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .CLK         (clk),
        .CLB         (rst),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .reload      (reload),
        .fetch_addr  (fetch_addr),
        .fetch_data  (fetch_data),
        .fetch_valid (fetch_valid),
        .prog_len    (prog_len),
        .fault       (fault),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, want completion)");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver: one word, held until accepted (bounded)
    task automatic drive_word(input logic [7:0] d, input logic last);
        int n;
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        n = 0;
        while (!load_ready && n < 50) begin
            tick();
            n++;
        end
        if (!load_ready) begin
            errors++;
            $display("FAIL load_ready_timeout: got load_ready=%0b want 1", load_ready);
        end
        checks++;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic do_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
    endtask

    task automatic load_program();
        for (int i = 0; i < 19; i++) drive_word(prog[i], i == 18);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        reload = 1'b0; fetch_addr = '0;
        #12;
        rst = 1'b0;
        tick();
        checks++;
        if (dbg_state !== EMPTY || prog_len !== 6'd0) begin
            errors++;
            $display("FAIL reset_state: got state=%0d len=%0d want state=0 len=0", dbg_state, prog_len);
        end
        checks++;
        if (fetch_data !== NOP || fetch_valid !== 1'b0 || fault !== 1'b0 || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs: got data=%h valid=%0b fault=%0b ready=%0b want 00 0 0 1",
                     fetch_data, fetch_valid, fault, load_ready);
        end
    endtask

    task automatic test_load_and_run();
        load_program();
        checks++;
        if (prog_len !== 6'd19 || dbg_state !== READY || load_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_done: got len=%0d state=%0d ready=%0b want 19 2 0", prog_len, dbg_state, load_ready);
        end
        for (int i = 0; i < 19; i++) begin
            fetch_addr = 8'(i);
            tick();
            checks++;
            if (fetch_data !== prog[i] || fetch_valid !== 1'b1) begin
                errors++;
                $display("FAIL fetch_sweep[%0d]: got %h valid=%0b want %h valid=1", i, fetch_data, fetch_valid, prog[i]);
            end
        end
    endtask

    task automatic test_past_end();
        fetch_addr = 8'd25;
        tick();
        checks++;
        if (fetch_data !== HALT || fault !== 1'b0) begin
            errors++;
            $display("FAIL past_end: got data=%h fault=%0b want f0 0", fetch_data, fault);
        end
    endtask

    task automatic test_out_of_range();
        fetch_addr = 8'd40;
        tick();
        fetch_addr = 8'd3;
        tick();
`ifdef PROGMEM_FAULT_EN
        checks++;
        if (fault !== 1'b1) begin
            errors++;
            $display("FAIL fault_sticky: got fault=%0b want 1", fault);
        end
        fetch_addr = 8'd40;
        tick();
        checks++;
        if (fetch_data !== HALT || fault !== 1'b1) begin
            errors++;
            $display("FAIL oob_fetch: got data=%h fault=%0b want f0 1", fetch_data, fault);
        end
        do_reload();
        checks++;
        if (fault !== 1'b0) begin
            errors++;
            $display("FAIL fault_clear: got fault=%0b want 0", fault);
        end
        load_program();
`else
        checks++;
        if (fetch_data !== prog[3] || fault !== 1'b0) begin
            errors++;
            $display("FAIL after_wrap: got data=%h fault=%0b want %h 0", fetch_data, fault, prog[3]);
        end
        fetch_addr = 8'd40;
        tick();
        checks++;
        if (fetch_data !== prog[8] || fault !== 1'b0) begin
            errors++;
            $display("FAIL wrap_fetch: got data=%h fault=%0b want %h 0", fetch_data, fault, prog[8]);
        end
`endif
    endtask

    task automatic test_reload_collision();
        fetch_addr = 8'd0;
        reload = 1'b1;
        tick();
        reload = 1'b0;
        checks++;
        if (fetch_data !== NOP || fetch_valid !== 1'b0 || prog_len !== 6'd0 || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL reload_collision: got data=%h valid=%0b len=%0d ready=%0b want 00 0 0 1",
                     fetch_data, fetch_valid, prog_len, load_ready);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] w;
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) tick();
            w = 8'(8'h40 + i * 5);
            exp_q.push_back(w);
            drive_word(w, 1'b0);
        end
        checks++;
        if (dbg_state !== READY || load_ready !== 1'b0 || prog_len !== 6'd32) begin
            errors++;
            $display("FAIL full_no_last: got state=%0d ready=%0b len=%0d want 2 0 32", dbg_state, load_ready, prog_len);
        end
        for (int i = 0; i < DEPTH; i++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            fetch_addr = 8'(i);
            tick();
            checks++;
            if (fetch_data !== e) begin
                errors++;
                $display("FAIL bp_readback[%0d]: got %h want %h", i, fetch_data, e);
            end
        end
    endtask

    task automatic test_reload_with_load();
        do_reload();
        load_valid = 1'b1; load_data = 8'h77; load_last = 1'b0;
        reload = 1'b1;
        tick();
        reload = 1'b0; load_valid = 1'b0;
        checks++;
        if (prog_len !== 6'd0 || dbg_state !== EMPTY) begin
            errors++;
            $display("FAIL reload_drop: got len=%0d state=%0d want 0 0", prog_len, dbg_state);
        end
    endtask

    task automatic test_reset_mid_load();
        for (int i = 0; i < 5; i++) drive_word(8'(8'h10 + i), 1'b0);
        checks++;
        if (prog_len !== 6'd5 || dbg_state !== LOADING) begin
            errors++;
            $display("FAIL mid_load: got len=%0d state=%0d want 5 1", prog_len, dbg_state);
        end
        #2 rst = 1'b1;
        #3;
        checks++;
        if (prog_len !== 6'd0 || dbg_state !== EMPTY) begin
            errors++;
            $display("FAIL reset_abort: got len=%0d state=%0d want 0 0", prog_len, dbg_state);
        end
        rst = 1'b0;
        tick();
        drive_word(8'hAA, 1'b0);
        drive_word(8'hBB, 1'b1);
        fetch_addr = 8'd2;
        tick();
        checks++;
        if (fetch_data !== HALT || fetch_valid !== 1'b1) begin
            errors++;
            $display("FAIL addr2_halt: got %h valid=%0b want f0 1", fetch_data, fetch_valid);
        end
        fetch_addr = 8'd1;
        tick();
        checks++;
        if (fetch_data !== 8'hBB) begin
            errors++;
            $display("FAIL addr1_word: got %h want bb", fetch_data);
        end
    endtask

    initial begin
        test_reset();
        test_load_and_run();
        test_past_end();
        test_out_of_range();
        test_reload_collision();
        test_backpressure();
        test_reload_with_load();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
